slot_payout_judge: RTL and testbench

- Downstream consumer of the three-reel slot stage.
- Watches the spin mode and the final-reel carry, then latches the three stopped BCD digits and classifies the result (triple 7, triple, pair, loss).
- Keeps a 3-digit BCD credit balance: charges one credit per spin and pays winnings one credit per tick, so the 7-segment credit display counts up visibly.
- Drives a win level and a flash strobe for the display mux.

---
 rtl/slot_payout_judge_pkg.sv | 33 +++
 rtl/slot_payout_judge_if.sv | 29 ++
 rtl/slot_payout_judge_credit_counter.sv | 67 ++++++
 rtl/slot_payout_judge.sv | 151 +++++++++++++++
 tb/tb_slot_payout_judge.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/slot_payout_judge_pkg.sv
// Shared types for the slot payout judge: win classes, FSM states and BCD helpers.
package slot_pkg;

  typedef enum logic [1:0] {
    WIN_LOSS    = 2'd0,
    WIN_PAIR    = 2'd1,
    WIN_TRIPLE  = 2'd2,
    WIN_TRIPLE7 = 2'd3
  } win_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPIN   = 3'd1,
    JUDGE  = 3'd2,
    PAYOUT = 3'd3,
    SHOW   = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         FLASH_HALF = 25;

  // Triple beats pair, and 7-7-7 beats a plain triple.
  function automatic win_t classify(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    if (a == b && b == c) return (a == 4'd7) ? WIN_TRIPLE7 : WIN_TRIPLE;
    if (a == b || b == c || a == c) return WIN_PAIR;
    return WIN_LOSS;
  endfunction

  function automatic logic [11:0] bin_to_bcd(input int value);
    return {4'((value / 100) % 10), 4'((value / 10) % 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/slot_payout_judge_if.sv
// Reel inputs and credit/win display outputs of the payout judge.
interface slot_payout_judge_if;
  import slot_pkg::*;

  logic       tick;
  logic       mode;
  logic       carry3;
  logic [3:0] reel_bcd1;
  logic [3:0] reel_bcd2;
  logic [3:0] reel_bcd3;
  logic       spin_allow;
  logic [3:0] credit_bcd0;
  logic [3:0] credit_bcd1;
  logic [3:0] credit_bcd2;
  win_t       win_level;
  logic       win_flash;
  logic       busy;

  modport master (
    output tick, mode, carry3, reel_bcd1, reel_bcd2, reel_bcd3,
    input  spin_allow, credit_bcd0, credit_bcd1, credit_bcd2, win_level, win_flash, busy
  );

  modport slave (
    input  tick, mode, carry3, reel_bcd1, reel_bcd2, reel_bcd3,
    output spin_allow, credit_bcd0, credit_bcd1, credit_bcd2, win_level, win_flash, busy
  );

endinterface

// File: rtl/slot_payout_judge_credit_counter.sv
// Three-digit BCD up/down counter that saturates at 000 and 999.
module slot_credit_counter
  import slot_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic [11:0] load_bcd,
  input  logic        inc,
  input  logic        dec,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic        is_zero,
  output logic        is_max
);

  logic [3:0] digit_reg  [3];
  logic [3:0] digit_next [3];
  logic       chain;

  assign bcd0    = digit_reg[0];
  assign bcd1    = digit_reg[1];
  assign bcd2    = digit_reg[2];
  assign is_zero = (digit_reg[0] == 4'd0) && (digit_reg[1] == 4'd0) && (digit_reg[2] == 4'd0);
  assign is_max  = (digit_reg[0] == BCD_MAX) && (digit_reg[1] == BCD_MAX) && (digit_reg[2] == BCD_MAX);

  // chain is the carry on increment and the borrow on decrement.
  always_comb begin
    digit_next = digit_reg;
    chain      = 1'b0;
    if (inc && !is_max) begin
      chain = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (chain) begin
          if (digit_reg[i] == BCD_MAX) begin
            digit_next[i] = 4'd0;
          end else begin
            digit_next[i] = digit_reg[i] + 4'd1;
            chain         = 1'b0;
          end
        end
      end
    end else if (dec && !is_zero) begin
      chain = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (chain) begin
          if (digit_reg[i] == 4'd0) begin
            digit_next[i] = BCD_MAX;
          end else begin
            digit_next[i] = digit_reg[i] - 4'd1;
            chain         = 1'b0;
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
      always_ff @(posedge clk) begin
        if (load) digit_reg[gi] <= load_bcd[gi*4 +: 4];
        else      digit_reg[gi] <= digit_next[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/slot_payout_judge.sv
// Judges the stopped reels, charges one credit per spin and pays winnings one credit per tick.
module slot_payout_judge
  import slot_pkg::*;
#(
  parameter int INIT_CREDIT = 10,
  parameter int PAY_TRIPLE7 = 100,
  parameter int PAY_TRIPLE  = 30,
  parameter int PAY_PAIR    = 2,
  parameter int FLASH_TICKS = 50
) (
  input logic                clk,
  input logic                rst,
  slot_payout_judge_if.slave bus
);

  localparam logic [11:0] INIT_BCD = bin_to_bcd(INIT_CREDIT);

  state_t      state_reg, state_next;
  logic        mode_d_reg, carry_d_reg;
  logic [11:0] reels_reg, reels_next;
  win_t        win_reg, win_next;
  logic [6:0]  pay_reg, pay_next;
  logic [6:0]  show_cnt_reg, show_cnt_next;
  logic [4:0]  phase_reg, phase_next;
  logic        flash_reg, flash_next;
  logic        start, done, inc, dec, is_zero, is_max;
  win_t        judged;
  logic [6:0]  judged_pay;

  assign start  = bus.mode & ~mode_d_reg;
  assign done   = bus.carry3 & ~carry_d_reg & bus.mode;
  assign judged = classify(reels_reg[3:0], reels_reg[7:4], reels_reg[11:8]);

  always_comb begin
    case (judged)
      WIN_TRIPLE7: judged_pay = 7'(PAY_TRIPLE7);
      WIN_TRIPLE:  judged_pay = 7'(PAY_TRIPLE);
      WIN_PAIR:    judged_pay = 7'(PAY_PAIR);
      default:     judged_pay = 7'd0;
    endcase
  end

  slot_credit_counter u_credit (
    .clk      (clk),
    .load     (rst),
    .load_bcd (INIT_BCD),
    .inc      (inc),
    .dec      (dec),
    .bcd0     (bus.credit_bcd0),
    .bcd1     (bus.credit_bcd1),
    .bcd2     (bus.credit_bcd2),
    .is_zero  (is_zero),
    .is_max   (is_max)
  );

  always_comb begin
    state_next    = state_reg;
    reels_next    = reels_reg;
    win_next      = win_reg;
    pay_next      = pay_reg;
    show_cnt_next = '0;
    phase_next    = '0;
    flash_next    = 1'b0;
    inc           = 1'b0;
    dec           = 1'b0;
    case (state_reg)
      IDLE: begin
        // A start with no credit is tolerated: nothing is charged and nothing is judged.
        if (start && !is_zero) begin
          dec        = 1'b1;
          win_next   = WIN_LOSS;
          state_next = SPIN;
        end
      end
      SPIN: begin
        if (done) begin
          reels_next = {bus.reel_bcd3, bus.reel_bcd2, bus.reel_bcd1};
          state_next = JUDGE;
        end else if (!bus.mode) begin
          state_next = IDLE;
        end
      end
      JUDGE: begin
        win_next   = judged;
        pay_next   = judged_pay;
        state_next = (judged_pay != 7'd0) ? PAYOUT : SHOW;
      end
      PAYOUT: begin
        // Saturation is handled by the counter; the remaining payout still drains.
        if (pay_reg == 7'd0) begin
          state_next = SHOW;
        end else if (bus.tick) begin
          inc      = 1'b1;
          pay_next = pay_reg - 7'd1;
        end
      end
      SHOW: begin
        show_cnt_next = show_cnt_reg;
        phase_next    = phase_reg;
        flash_next    = flash_reg;
        if (bus.tick) begin
          if (show_cnt_reg == 7'(FLASH_TICKS - 1)) begin
            state_next    = IDLE;
            show_cnt_next = '0;
            phase_next    = '0;
            flash_next    = 1'b0;
          end else begin
            show_cnt_next = show_cnt_reg + 7'd1;
            if (phase_reg == 5'(FLASH_HALF - 1)) begin
              phase_next = '0;
              flash_next = flash_reg ^ (win_reg != WIN_LOSS);
            end else begin
              phase_next = phase_reg + 5'd1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_d_reg   <= 1'b0;
      carry_d_reg  <= 1'b0;
      reels_reg    <= '0;
      win_reg      <= WIN_LOSS;
      pay_reg      <= '0;
      show_cnt_reg <= '0;
      phase_reg    <= '0;
      flash_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_d_reg   <= bus.mode;
      carry_d_reg  <= bus.carry3;
      reels_reg    <= reels_next;
      win_reg      <= win_next;
      pay_reg      <= pay_next;
      show_cnt_reg <= show_cnt_next;
      phase_reg    <= phase_next;
      flash_reg    <= flash_next;
    end
  end

  assign bus.spin_allow = (state_reg == IDLE) && !is_zero;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.win_level  = win_reg;
  assign bus.win_flash  = flash_reg;

endmodule

// File: tb/tb_slot_payout_judge.sv
// Bench for slot_payout_judge: two instances (credit 10 and 998) checked against a behavioural model.
module tb_slot_payout_judge;
  import slot_pkg::*;

  localparam int M_IDLE = 0, M_SPIN = 1, M_JUDGE = 2, M_PAY = 3, M_SHOW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, mode = 1'b0, carry3 = 1'b0;
  logic [3:0] r1 = 4'd0, r2 = 4'd0, r3 = 4'd0;

  always #5 clk = ~clk;

  slot_payout_judge_if bus_a();
  slot_payout_judge_if bus_b();

  assign bus_a.tick = tick;      assign bus_b.tick = tick;
  assign bus_a.mode = mode;      assign bus_b.mode = mode;
  assign bus_a.carry3 = carry3;  assign bus_b.carry3 = carry3;
  assign bus_a.reel_bcd1 = r1;   assign bus_b.reel_bcd1 = r1;
  assign bus_a.reel_bcd2 = r2;   assign bus_b.reel_bcd2 = r2;
  assign bus_a.reel_bcd3 = r3;   assign bus_b.reel_bcd3 = r3;

  slot_payout_judge #(.INIT_CREDIT(10))  dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  slot_payout_judge #(.INIT_CREDIT(998)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int n_printed = 0;

  // Behavioural model: integer credit balance and a win class per spin.
  int m_state [2];
  int m_credit[2];
  int m_win   [2];
  int m_class [2];
  int m_pay   [2];
  int m_ticks [2];
  bit m_flash [2];
  bit m_mode_d[2];
  bit m_carry_d[2];
  int init_credit[2] = '{10, 998};
  int pay_of[4] = '{0, 2, 30, 100};

  function automatic int judge_of(input int a, input int b, input int c);
    int eq;
    eq = int'(a == b) + int'(b == c) + int'(a == c);
    if (eq == 3) return (a == 7) ? 3 : 2;
    if (eq == 1) return 1;
    return 0;
  endfunction

  task automatic model_step(input int k);
    bit st, dn;
    if (rst) begin
      m_state[k] = M_IDLE; m_credit[k] = init_credit[k]; m_win[k] = 0; m_class[k] = 0;
      m_pay[k] = 0; m_ticks[k] = 0; m_flash[k] = 0; m_mode_d[k] = 0; m_carry_d[k] = 0;
      return;
    end
    st = mode && !m_mode_d[k];
    dn = carry3 && !m_carry_d[k] && mode;
    case (m_state[k])
      M_IDLE: if (st && m_credit[k] > 0) begin
        m_credit[k]--; m_win[k] = 0; m_state[k] = M_SPIN;
      end
      M_SPIN: if (dn) begin
        m_class[k] = judge_of(int'(r1), int'(r2), int'(r3)); m_state[k] = M_JUDGE;
      end else if (!mode) m_state[k] = M_IDLE;
      M_JUDGE: begin
        m_win[k] = m_class[k]; m_pay[k] = pay_of[m_class[k]]; m_ticks[k] = 0;
        m_state[k] = (m_pay[k] > 0) ? M_PAY : M_SHOW;
      end
      M_PAY: if (m_pay[k] == 0) m_state[k] = M_SHOW;
      else if (tick) begin
        if (m_credit[k] < 999) m_credit[k]++;
        m_pay[k]--;
      end
      M_SHOW: if (tick) begin
        m_ticks[k]++;
        if (m_ticks[k] == 50) begin m_state[k] = M_IDLE; m_flash[k] = 0; end
        else if (m_ticks[k] % 25 == 0 && m_win[k] != 0) m_flash[k] = !m_flash[k];
      end
      default: m_state[k] = M_IDLE;
    endcase
    m_mode_d[k] = mode;
    m_carry_d[k] = carry3;
  endtask

  function automatic logic [16:0] model_obs(input int k);
    int c;
    c = m_credit[k];
    return {(m_state[k] == M_IDLE) && (c > 0), m_state[k] != M_IDLE, m_flash[k], 2'(m_win[k]),
            4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [16:0] dut_obs(input int k);
    if (k == 0)
      return {bus_a.spin_allow, bus_a.busy, bus_a.win_flash, bus_a.win_level,
              bus_a.credit_bcd2, bus_a.credit_bcd1, bus_a.credit_bcd0};
    return {bus_b.spin_allow, bus_b.busy, bus_b.win_flash, bus_b.win_level,
            bus_b.credit_bcd2, bus_b.credit_bcd1, bus_b.credit_bcd0};
  endfunction

  function automatic logic [11:0] credit_a();
    return {bus_a.credit_bcd2, bus_a.credit_bcd1, bus_a.credit_bcd0};
  endfunction

  function automatic logic [11:0] credit_b();
    return {bus_b.credit_bcd2, bus_b.credit_bcd1, bus_b.credit_bcd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_printed < 40) begin
        n_printed++;
        $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
    end
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check("lockstep_a", 32'(dut_obs(0)), 32'(model_obs(0)));
    check("lockstep_b", 32'(dut_obs(1)), 32'(model_obs(1)));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; mode = 1'b0; carry3 = 1'b0;
    cycle();
    check("reset_state_a", 32'(dut_obs(0)), 32'({1'b1, 1'b0, 1'b0, 2'd0, 12'h010}));
    rst = 1'b0;
  endtask

  task automatic spin_start();
    mode = 1'b1; carry3 = 1'b0; tick = 1'b1;
    cycle();
  endtask

  // Stop the reels, then run until both instances are idle; counts dut_b busy and dut_a flash samples.
  task automatic spin_finish(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             output int n_busy, output int n_flash);
    int guard;
    n_busy = 0; n_flash = 0; guard = 0;
    cycle();
    cycle();
    r1 = a; r2 = b; r3 = c; carry3 = 1'b1;
    cycle();
    while ((bus_a.busy || bus_b.busy) && guard < 400) begin
      if (bus_b.busy) n_busy++;
      if (bus_a.win_flash) n_flash++;
      cycle();
      guard++;
    end
    if (guard >= 400) begin
      n_bad++; n_cmp++;
      $display("FAIL idle_timeout @%0t: still busy after %0d cycles, required idle", $time, guard);
    end
    mode = 1'b0; carry3 = 1'b0;
    cycle();
  endtask

  task automatic spin(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      output int n_busy, output int n_flash);
    spin_start();
    spin_finish(a, b, c, n_busy, n_flash);
  endtask

  typedef struct {
    logic [3:0]  a, b, c;
    logic [1:0]  win;
    logic [11:0] credit;
    int          flash;
    int          busy;
  } vec_t;

  vec_t vecs[8];
  int nb, nf;

  initial begin
    vecs[0] = '{4'd7, 4'd7, 4'd7, 2'd3, 12'h109, 25, 152};
    vecs[1] = '{4'd3, 4'd5, 4'd3, 2'd1, 12'h110, 25, 54};
    vecs[2] = '{4'd1, 4'd2, 4'd4, 2'd0, 12'h109, 0, 51};
    vecs[3] = '{4'd4, 4'd4, 4'd4, 2'd2, 12'h138, 25, 82};
    vecs[4] = '{4'd9, 4'd9, 4'd8, 2'd1, 12'h139, 25, 54};
    vecs[5] = '{4'd0, 4'd7, 4'd7, 2'd1, 12'h140, 25, 54};
    vecs[6] = '{4'd7, 4'd7, 4'd1, 2'd1, 12'h141, 25, 54};
    vecs[7] = '{4'd5, 4'd0, 4'd2, 2'd0, 12'h140, 0, 51};

    // Triple 4 from reset: dut_b saturates at 999 yet payout still lasts 30 ticks.
    do_reset();
    spin_start();
    check("start_charge_a", 32'(credit_a()), 32'h009);
    check("start_charge_b", 32'(credit_b()), 32'h997);
    check("start_busy_a", 32'(bus_a.busy), 32'd1);
    spin_finish(4'd4, 4'd4, 4'd4, nb, nf);
    check("triple_credit_a", 32'(credit_a()), 32'h039);
    check("saturate_credit_b", 32'(credit_b()), 32'h999);
    check("triple_win_a", 32'(bus_a.win_level), 32'd2);
    check("saturate_busy_len_b", 32'(nb), 32'd82);
    check("triple_flash_a", 32'(nf), 32'd25);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      spin(vecs[i].a, vecs[i].b, vecs[i].c, nb, nf);
      $display("vec %0d reels %0d%0d%0d: win %0d credit %03h flash %0d busy %0d",
               i, vecs[i].a, vecs[i].b, vecs[i].c, bus_a.win_level, credit_a(), nf, nb);
      check("vec_win", 32'(bus_a.win_level), 32'(vecs[i].win));
      check("vec_credit", 32'(credit_a()), 32'(vecs[i].credit));
      check("vec_flash", 32'(nf), 32'(vecs[i].flash));
      check("vec_busy_len", 32'(nb), 32'(vecs[i].busy));
    end

    // Abort during SPIN: back to IDLE and the charged credit stays gone.
    spin_start();
    cycle();
    mode = 1'b0;
    cycle();
    check("abort_busy_a", 32'(bus_a.busy), 32'd0);
    check("abort_credit_a", 32'(credit_a()), 32'h139);

    // Reset five ticks into a 7-7-7 payout.
    spin_start();
    cycle();
    r1 = 4'd7; r2 = 4'd7; r3 = 4'd7; carry3 = 1'b1;
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    check("mid_payout_credit_a", 32'(credit_a()), 32'h143);
    rst = 1'b1;
    cycle();
    check("mid_payout_reset_a", 32'(dut_obs(0)), 32'({1'b1, 1'b0, 1'b0, 2'd0, 12'h010}));
    rst = 1'b0; mode = 1'b0; carry3 = 1'b0;
    cycle();

    // Drain dut_a to zero with losing spins; a further start is free and unjudged.
    for (int i = 0; i < 10; i++) spin(4'd1, 4'd2, 4'd4, nb, nf);
    check("drain_credit_a", 32'(credit_a()), 32'h000);
    check("drain_allow_a", 32'(bus_a.spin_allow), 32'd0);
    mode = 1'b1;
    cycle();
    check("free_spin_busy_a", 32'(bus_a.busy), 32'd0);
    check("free_spin_credit_a", 32'(credit_a()), 32'h000);
    mode = 1'b0;
    cycle();

    // Randomised traffic, checked every cycle against the model.
    do_reset();
    for (int n = 0; n < 8000; n++) begin
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 11) == 0) carry3 = ~carry3;
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        r1 = ($urandom_range(0, 3) == 0) ? 4'd7 : 4'($urandom_range(0, 9));
        r2 = ($urandom_range(0, 1) == 0) ? r1 : 4'($urandom_range(0, 9));
        r3 = ($urandom_range(0, 1) == 0) ? r1 : 4'($urandom_range(0, 9));
      end
      rst = ($urandom_range(0, 2999) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
